// File: rtl/axi_4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Optional error counter (ERR_COUNT port) is built when AXI_MASTER_ERR_COUNT_EN is defined.
`timescale 1ns/1ps
module axi_4_lite_master #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDRESS-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_WRITE,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
`ifdef AXI_MASTER_ERR_COUNT_EN
  ,
  output logic [15:0]             ERR_COUNT
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q;
  logic                  aw_valid_q, w_valid_q, ar_valid_q;
  logic [ADDRESS-1:0]    addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic cmd_accept, aw_done, w_done, b_hs, r_hs;

  // cmd_ready_q is only ever high in IDLE, so it alone qualifies acceptance
  assign cmd_accept = CMD_VALID && cmd_ready_q;
  assign aw_done    = !aw_valid_q || M_AWREADY;
  assign w_done     = !w_valid_q || M_WREADY;
  assign b_hs       = (state_q == WR_RESP) && M_BVALID;
  assign r_hs       = (state_q == RD_RESP) && M_RVALID;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept) state_d = CMD_WRITE ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
      WR_RESP: if (M_BVALID) state_d = RSP;
      RD_REQ:  if (M_ARREADY) state_d = RD_RESP;
      RD_RESP: if (M_RVALID) state_d = RSP;
      RSP:     if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CMD_READY is registered so it stays low through reset and rises one edge after release
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
    end else if (cmd_accept) begin
      aw_valid_q <= CMD_WRITE;
      w_valid_q  <= CMD_WRITE;
      ar_valid_q <= !CMD_WRITE;
    end else begin
      if (aw_valid_q && M_AWREADY) aw_valid_q <= 1'b0;
      if (w_valid_q && M_WREADY)   w_valid_q  <= 1'b0;
      if (ar_valid_q && M_ARREADY) ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_accept) begin
      addr_q  <= CMD_ADDR;
      wdata_q <= CMD_WRITE ? CMD_WDATA : '0;
      wstrb_q <= CMD_WRITE ? CMD_WSTRB : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else if (b_hs) begin
      rsp_write_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= M_BRESP;
    end else if (r_hs) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= M_RDATA;
      rsp_resp_q  <= M_RRESP;
    end
  end

`ifdef AXI_MASTER_ERR_COUNT_EN
  logic [15:0] err_count_q;
  logic        err_event;

  assign err_event = (b_hs && (M_BRESP != 2'b00)) || (r_hs && (M_RRESP != 2'b00));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      err_count_q <= 16'h0000;
    else if (err_event && (err_count_q != 16'hFFFF))
      err_count_q <= err_count_q + 16'h0001;
  end

  assign ERR_COUNT = err_count_q;
`endif

  assign CMD_READY = cmd_ready_q;
  assign M_AWADDR  = addr_q;
  assign M_AWVALID = aw_valid_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WVALID  = w_valid_q;
  assign M_BREADY  = (state_q == WR_RESP);
  assign M_ARADDR  = addr_q;
  assign M_ARVALID = ar_valid_q;
  assign M_RREADY  = (state_q == RD_RESP);
  assign RSP_VALID = (state_q == RSP);
  assign RSP_WRITE = rsp_write_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;

endmodule

// File: tb/tb_axi_4_lite_master.sv
// Bench for axi_4_lite_master: a behavioural AXI4-Lite slave with controllable stalls,
// plus a word-array reference model that predicts every response.
`timescale 1ns/1ps
module tb_axi_4_lite_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic        RSP_VALID, RSP_READY, RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [3:0]  M_WSTRB;
  logic [1:0]  M_BRESP, M_RRESP;
`ifdef AXI_MASTER_ERR_COUNT_EN
  logic [15:0] ERR_COUNT;
  logic [15:0] exp_err = 16'h0;
`endif

  always #5 CLK = ~CLK;

  axi_4_lite_master dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
`ifdef AXI_MASTER_ERR_COUNT_EN
    , .ERR_COUNT(ERR_COUNT)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int cmds_done = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // Behavioural slave: 16 words at 0x00..0x3C, SLVERR (2'b10) anywhere else
  logic        slv_rand = 1'b0;
  logic        w_hold_arm = 1'b0;
  logic        b_hold = 1'b0;
  logic [31:0] slv_mem [16];
  logic        aw_got, w_got, b_pend;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic [1:0]  bresp_l;
  int          w_hold_cnt;
  logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign aw_hs   = M_AWVALID && M_AWREADY;
  assign w_hs    = M_WVALID && M_WREADY;
  assign ar_hs   = M_ARVALID && M_ARREADY;
  assign have_aw = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;
  assign wr_addr = aw_hs ? M_AWADDR : aw_addr_l;
  assign wr_data = w_hs ? M_WDATA : w_data_l;
  assign wr_strb = w_hs ? M_WSTRB : w_strb_l;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; w_hold_cnt <= 0;
      M_AWREADY <= 1'b0; M_WREADY <= 1'b0; M_ARREADY <= 1'b0;
      M_BVALID <= 1'b0; M_RVALID <= 1'b0; M_BRESP <= 2'b00; M_RRESP <= 2'b00; M_RDATA <= '0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; bresp_l <= 2'b00;
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= M_AWADDR; end
      if (w_hs) begin w_got <= 1'b1; w_data_l <= M_WDATA; w_strb_l <= M_WSTRB; end
      if (have_aw && have_w && !M_BVALID && !b_pend) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (wr_addr < 32'h40) slv_mem[wr_addr[5:2]] <= mergeBytes(slv_mem[wr_addr[5:2]], wr_data, wr_strb);
        if (b_hold) begin
          b_pend  <= 1'b1;
          bresp_l <= (wr_addr < 32'h40) ? 2'b00 : 2'b10;
        end else begin
          M_BVALID <= 1'b1;
          M_BRESP  <= (wr_addr < 32'h40) ? 2'b00 : 2'b10;
        end
      end else if (b_pend && !b_hold) begin
        b_pend   <= 1'b0;
        M_BVALID <= 1'b1;
        M_BRESP  <= bresp_l;
      end
      if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
      if (ar_hs) begin
        M_RVALID <= 1'b1;
        M_RDATA  <= (M_ARADDR < 32'h40) ? slv_mem[M_ARADDR[5:2]] : 32'h0;
        M_RRESP  <= (M_ARADDR < 32'h40) ? 2'b00 : 2'b10;
      end
      if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
      M_AWREADY <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      M_ARREADY <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_hold_arm) begin
        if (aw_hs) begin
          w_hold_cnt <= 3;
          M_WREADY   <= 1'b0;
        end else if (w_hold_cnt > 0) begin
          w_hold_cnt <= w_hold_cnt - 1;
          M_WREADY   <= (w_hold_cnt == 1);
        end else begin
          M_WREADY <= 1'b0;
        end
      end else begin
        M_WREADY <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET && RSP_VALID && RSP_READY) rsp_seen <= rsp_seen + 1;
  end

  // Protocol monitor: a VALID waiting on its READY must hold with stable payload
  logic        pv_aw, pv_w, pv_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pv_aw <= 1'b0; pv_w <= 1'b0; pv_ar <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
    end else begin
      pv_aw <= M_AWVALID && !M_AWREADY; p_awaddr <= M_AWADDR;
      pv_w  <= M_WVALID && !M_WREADY;   p_wdata  <= M_WDATA; p_wstrb <= M_WSTRB;
      pv_ar <= M_ARVALID && !M_ARREADY; p_araddr <= M_ARADDR;
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (pv_aw) checkOutput("aw_hold", 64'({M_AWVALID, M_AWADDR}), 64'({1'b1, p_awaddr}));
      if (pv_w)  checkOutput("w_hold", 64'({M_WVALID, M_WSTRB, M_WDATA}), 64'({1'b1, p_wstrb, p_wdata}));
      if (pv_ar) checkOutput("ar_hold", 64'({M_ARVALID, M_ARADDR}), 64'({1'b1, p_araddr}));
      if (M_BREADY) checkOutput("bready_early", 64'({M_AWVALID, M_WVALID, M_ARVALID, M_RREADY}), 64'd0);
      if (M_RREADY) checkOutput("rready_early", 64'({M_ARVALID, M_AWVALID, M_WVALID}), 64'd0);
    end
  end

  // Reference model: a plain word array updated in command order
  logic [31:0] ref_mem [16];

  task automatic refModel(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] exp_data, output logic [1:0] exp_resp);
    exp_data = 32'h0;
    exp_resp = (addr < 32'h40) ? 2'b00 : 2'b10;
    if (addr < 32'h40) begin
      if (wr) ref_mem[addr[5:2]] = mergeBytes(ref_mem[addr[5:2]], data, strb);
      else    exp_data = ref_mem[addr[5:2]];
    end
  endtask

  logic        pend_valid = 1'b0;
  logic        pend_wr;
  logic [31:0] pend_addr;

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int hold, output int lat, output int acc_cyc);
    logic [31:0] exp_data, held;
    logic [1:0]  exp_resp;
    int n;
    lat = 0;
    acc_cyc = 0;
    refModel(wr, addr, data, strb, exp_data, exp_resp);
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = data; CMD_WSTRB = strb;
    n = 0;
    while (!CMD_READY && n < 100) begin @(negedge CLK); n++; end
    if (!CMD_READY) begin
      checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
      CMD_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    acc_cyc = cyc;
    do begin @(negedge CLK); lat++; end while (!RSP_VALID && lat < 200);
    if (!RSP_VALID) begin
      checkOutput("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    held = RSP_RDATA;
    for (int i = 0; i < hold; i++) begin
      if (pend_valid) begin
        CMD_VALID = 1'b1; CMD_WRITE = pend_wr; CMD_ADDR = pend_addr; CMD_WDATA = 32'h0; CMD_WSTRB = 4'h0;
      end
      checkOutput("rsp_hold_valid", 64'(RSP_VALID), 64'd1);
      checkOutput("rsp_hold_data", 64'(RSP_RDATA), 64'(held));
      checkOutput("cmd_ready_busy", 64'(CMD_READY), 64'd0);
      @(negedge CLK);
    end
    checkOutput("rsp_write", 64'(RSP_WRITE), 64'(wr));
    checkOutput("rsp_rdata", 64'(RSP_RDATA), 64'(exp_data));
    checkOutput("rsp_resp", 64'(RSP_RESP), 64'(exp_resp));
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    cmds_done++;
`ifdef AXI_MASTER_ERR_COUNT_EN
    if (exp_resp != 2'b00 && exp_err != 16'hFFFF) exp_err++;
    checkOutput("err_count", 64'(ERR_COUNT), 64'(exp_err));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({CMD_READY, RSP_VALID, RSP_WRITE, RSP_RESP, M_AWVALID, M_WVALID,
                                     M_BREADY, M_ARVALID, M_RREADY, M_WSTRB}), 64'd0);
    checkOutput({tag, "_addr"}, {M_AWADDR, M_ARADDR}, 64'd0);
    checkOutput({tag, "_data"}, {M_WDATA, RSP_RDATA}, 64'd0);
`ifdef AXI_MASTER_ERR_COUNT_EN
    checkOutput({tag, "_err"}, 64'(ERR_COUNT), 64'd0);
`endif
  endtask

  int lat, acc, prev_acc, n, rsp_before;
  logic [31:0] addr, data;

  initial begin
    RESET = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
    RSP_READY = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    #1 checkAllZero("reset");
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    checkOutput("ready_in_reset_release", 64'(CMD_READY), 64'd0);
    @(negedge CLK);
    checkOutput("ready_after_release", 64'(CMD_READY), 64'd1);

    // Basic write then read with a zero-wait slave
    applyStimulus(1'b1, 32'h0, 32'h12345678, 4'hF, 0, lat, acc);
    checkOutput("wr_latency", 64'(lat), 64'd3);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, lat, acc);
    checkOutput("rd_latency", 64'(lat), 64'd3);

    // W channel stalled three cycles after AW
    w_hold_arm = 1'b1;
    fork
      applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, lat, acc);
      begin
        logic [3:0] exp_tbl [6];
        exp_tbl[0] = 4'b1100; exp_tbl[1] = 4'b0100; exp_tbl[2] = 4'b0100;
        exp_tbl[3] = 4'b0100; exp_tbl[4] = 4'b0110; exp_tbl[5] = 4'b0001;
        @(negedge CLK);
        for (int k = 0; k < 6; k++) begin
          @(negedge CLK);
          checkOutput($sformatf("wstall_k%0d", k), 64'({M_AWVALID, M_WVALID, M_WREADY, M_BREADY}), 64'(exp_tbl[k]));
          if (k < 5) checkOutput($sformatf("wstall_data_k%0d", k), 64'(M_WDATA), 64'h0000_0000_DEAD_BEEF);
        end
      end
    join
    w_hold_arm = 1'b0;

    // Out-of-range read returns the slave error code
    applyStimulus(1'b0, 32'h1030, 32'h0, 4'h0, 0, lat, acc);
    checkOutput("oor_resp", 64'(RSP_RESP), 64'd2);

    // Response back-pressure with a command waiting behind it
    pend_valid = 1'b1; pend_wr = 1'b0; pend_addr = 32'h4;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5, lat, prev_acc);
    pend_valid = 1'b0;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 0, lat, acc);
    checkOutput("pending_spacing", 64'(acc - prev_acc), 64'd9);

    // Back-to-back writes then reads: 4-cycle command spacing
    for (int i = 0; i < 8; i++) begin
      addr = 32'h30 + 32'(4 * (i % 4));
      applyStimulus(i < 4, addr, 32'h600DF00D + 32'(i % 4), 4'hF, 0, lat, acc);
      checkOutput($sformatf("b2b_lat%0d", i), 64'(lat), 64'd3);
      if (i > 0) checkOutput($sformatf("b2b_spacing%0d", i), 64'(acc - prev_acc), 64'd4);
      prev_acc = acc;
    end

    // Randomized traffic with a stalling slave
    slv_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 17);
      addr = (n == 17) ? 32'h1030 : 32'(n * 4);
      data = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), addr, data, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2), lat, acc);
    end
    slv_rand = 1'b0;

    // Reset while waiting for BRESP
    b_hold = 1'b1;
    rsp_before = rsp_seen;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h8; CMD_WDATA = 32'hCAFE0001; CMD_WSTRB = 4'hF;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    n = 0;
    while (!M_BREADY && n < 50) begin @(negedge CLK); n++; end
    checkOutput("reached_wr_resp", 64'(M_BREADY), 64'd1);
    #2 RESET = 1'b0;
    #1 checkAllZero("mid_reset");
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
`ifdef AXI_MASTER_ERR_COUNT_EN
    exp_err = 16'h0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("no_rsp_in_reset", 64'({RSP_VALID, CMD_READY}), 64'd0);
    end
    b_hold = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_mid_reset", 64'(CMD_READY), 64'd1);
    checkOutput("no_rsp_abandoned", 64'(rsp_seen), 64'(rsp_before));
    applyStimulus(1'b1, 32'hC, 32'hA5A55A5A, 4'hF, 0, lat, acc);
    checkOutput("post_reset_wr_lat", 64'(lat), 64'd3);
    applyStimulus(1'b0, 32'hC, 32'h0, 4'h0, 0, lat, acc);

    @(negedge CLK);
    checkOutput("rsp_count", 64'(rsp_seen), 64'(cmds_done + rsp_before - rsp_before));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got 0, expected 1");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/axi_4_lite_master.md
# axi_4_lite_master

Single-outstanding AXI4-Lite master that turns a simple command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of `axi_4_lite_slave` and drives its S_* channels. Local logic (sequencers, CPU bridge, test drivers) issues one command at a time and receives one response per command.

## Interface
Parameters:
- `ADDRESS`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; must be a multiple of 8. Strobe width is `DATA_WIDTH/8`.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  command accepted when `CMD_VALID && CMD_READY`.
- `CMD_WRITE`  in  1  1 = write, 0 = read.
- `CMD_ADDR`  in  ADDRESS  target address.
- `CMD_WDATA`  in  DATA_WIDTH  write data; ignored for reads.
- `CMD_WSTRB`  in  DATA_WIDTH/8  byte enables; ignored for reads.
- `RSP_VALID`  out  1  response present.
- `RSP_READY`  in  1  response consumed when `RSP_VALID && RSP_READY`.
- `RSP_WRITE`  out  1  echoes `CMD_WRITE` of the completed command.
- `RSP_RDATA`  out  DATA_WIDTH  read data; 0 for writes.
- `RSP_RESP`  out  2  BRESP or RRESP as returned by the slave.
- `M_AWADDR`/`M_AWVALID`/`M_AWREADY`, `M_WDATA`/`M_WSTRB`/`M_WVALID`/`M_WREADY`, `M_BRESP`/`M_BVALID`/`M_BREADY`, `M_ARADDR`/`M_ARVALID`/`M_ARREADY`, `M_RDATA`/`M_RRESP`/`M_RVALID`/`M_RREADY`: standard AXI4-Lite master side, with widths matching the slave's S_* ports.
- `ERR_COUNT`  out  16  only present with `AXI_MASTER_ERR_COUNT_EN`.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `CMD_READY`=1. When a command is accepted, the command is captured and the FSM moves to WR_REQ if `CMD_WRITE`, otherwise to RD_REQ.
- WR_REQ:
  - `M_AWVALID` and `M_WVALID` both assert on entry.
  - Each drops independently after its own handshake.
  - AW before W, W before AW, and both in the same cycle are all legal.
  - After both handshakes are complete, the FSM moves to WR_RESP.
- WR_RESP: `M_BREADY`=1. On a B handshake, `M_BRESP` is captured and the FSM moves to RSP.
- RD_REQ: `M_ARVALID`=1 until the AR handshake, then the FSM moves to RD_RESP.
- RD_RESP: `M_RREADY`=1. On an R handshake, `M_RDATA` and `M_RRESP` are captured and the FSM moves to RSP.
- RSP: `RSP_VALID`=1 and is held until `RSP_READY`, then the FSM returns to IDLE.
- VALID signals are never withdrawn before their handshake. Address, data and strobe are held stable from the captured command while VALID is high.
- BREADY and RREADY are asserted only in their wait states, never speculatively.
- At most one transaction is outstanding. There is no read/write interleaving.

## Timing
- Reset (asynchronous, `RESET`=0): FSM goes to IDLE.
  - `CMD_READY`=0 while in reset and 1 on the first cycle after release.
  - All `M_*VALID`, `M_BREADY`, `M_RREADY` and `RSP_VALID` = 0.
  - `M_AWADDR`, `M_WDATA`, `M_WSTRB`, `M_ARADDR`, `RSP_RDATA`, `RSP_RESP`, `RSP_WRITE` = 0.
  - `ERR_COUNT` = 0.
- Reset mid-transaction drops all outputs immediately. The transaction is abandoned and no response is produced.
- All outputs are registered or decoded from the registered state. There is no combinational path from `M_*READY` to `M_*VALID`.
- Command accepted at edge N: `M_AWVALID`/`M_WVALID` (or `M_ARVALID`) are high from cycle N+1.
- Zero-wait slave:
  - AW/W handshake at N+1.
  - `M_BREADY` high at N+2.
  - B handshake at N+2 at the earliest.
  - `RSP_VALID` at N+3.
  - Reads follow the same timing.
- Minimum command-to-command spacing is 4 cycles with zero-wait slave and consumer.
- `CMD_READY` is 0 in every state except IDLE. A command presented while busy waits; it is not dropped.

## Configuration
- `AXI_MASTER_ERR_COUNT_EN` defined:
  - `ERR_COUNT` port exists.
  - It increments by 1 on every B or R handshake whose resp is not 2'b00.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Write 0x12345678 to 0x0, WSTRB 4'b1111, then read 0x0 -> `RSP_RESP`=00, `RSP_WRITE`=1 then 0, `RSP_RDATA`=0x12345678. With a zero-wait slave, `RSP_VALID` comes exactly 3 cycles after command accept.
- Slave holds `M_WREADY` low 3 cycles after the AW handshake -> `M_AWVALID` drops after 1 cycle, `M_WVALID` stays high with stable 0xDEADBEEF, and BREADY asserts only after the W handshake.
- Read of out-of-range address 0x1030 -> `RSP_RESP` equals the slave's error code (nonzero), and `ERR_COUNT` goes 0->1 when the macro is enabled.
- Hold `RSP_READY` low 5 cycles after a completed read -> `RSP_VALID` and data stay stable, `CMD_READY` stays 0, and a pending `CMD_VALID` is accepted only after the response handshake.
- Four back-to-back writes to 0x30..0x3C (data 0x600DF00D+i) followed by four reads -> all readbacks match, and exactly one response is produced per command, in order.
- Assert reset while in WR_RESP -> all outputs are 0 within the same cycle, no response appears, and the next command after release completes normally.
